// File: rtl/read_query_server.sv
// ---------------------------------------------------------------------------
// read_query_server
//
// Read-side server for the SMEM forward/backward pipeline queue.
//  * Holds the current batch of reads as 4-bit bases (0-3 = ACGT, 4 = N) in a
//    READ_CNT x 128 base memory addressed {read_num, pos[6:0]}.
//  * Answers one base query per cycle with a fixed 3-cycle latency, matching
//    the queue's 3-stage wait pipe:
//      S1 register address + class, S2 synchronous memory read,
//      S3 register formatted response.
//  * Hands new-read descriptors to the queue through a show-ahead FIFO.
//
// Build option:
//  RQS_WR_BYPASS_EN - when defined, a base write to the address being read in
//                     S2 is forwarded to the read (write-first). When
//                     undefined, the read returns the previously stored base.
//
// Ports:
//  Clk_32UI, reset_n            clock, asynchronous active-low reset
//  base_wr_*                    host base write (en, read_num, pos, data)
//  batch_start / batch_done     clear / set load_done (done wins)
//  desc_valid / desc_ready      descriptor push handshake
//  desc_*                       descriptor payload (read_num, 4 x ik, forward_i)
//  new_read / new_read_valid    descriptor pop handshake from the queue
//  new_*                        head-of-FIFO descriptor (0 while empty)
//  load_done                    batch fully loaded
//  query_*_2RAM                 base query (pos 8'hFF or status 6'h3F = idle)
//  new_read_query_2Queue        query response: {4'h0,base}, 8'h04 OOR, 8'hFF idle
//  underflow_err                sticky: pop attempted on an empty FIFO
// ---------------------------------------------------------------------------
module read_query_server #(
    parameter int READ_CNT   = 1024,
    parameter int READ_LEN   = 101,
    parameter int DESC_DEPTH = 16
) (
    input  logic        Clk_32UI,
    input  logic        reset_n,
    input  logic        base_wr_en,
    input  logic [9:0]  base_wr_read_num,
    input  logic [6:0]  base_wr_pos,
    input  logic [3:0]  base_wr_data,
    input  logic        batch_start,
    input  logic        batch_done,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [9:0]  desc_read_num,
    input  logic [63:0] desc_ik_x0,
    input  logic [63:0] desc_ik_x1,
    input  logic [63:0] desc_ik_x2,
    input  logic [63:0] desc_ik_info,
    input  logic [6:0]  desc_forward_i,
    input  logic        new_read,
    output logic        new_read_valid,
    output logic        load_done,
    output logic [9:0]  new_read_num,
    output logic [63:0] new_ik_x0,
    output logic [63:0] new_ik_x1,
    output logic [63:0] new_ik_x2,
    output logic [63:0] new_ik_info,
    output logic [6:0]  new_forward_i,
    input  logic [7:0]  query_position_2RAM,
    input  logic [9:0]  query_read_num_2RAM,
    input  logic [5:0]  query_status_2RAM,
    output logic [7:0]  new_read_query_2Queue,
    output logic        underflow_err
);

    localparam int              AW        = $clog2(DESC_DEPTH);
    localparam int              PW        = AW + 1;
    localparam int              MEM_DEPTH = READ_CNT * 128;
    localparam logic [7:0]      LEN_LIM   = 8'(READ_LEN);

    typedef enum logic [1:0] {
        CLS_INVALID = 2'd0,
        CLS_OOR     = 2'd1,
        CLS_OK      = 2'd2
    } cls_t;

    typedef struct packed {
        logic [9:0]  read_num;
        logic [63:0] ik_x0;
        logic [63:0] ik_x1;
        logic [63:0] ik_x2;
        logic [63:0] ik_info;
        logic [6:0]  forward_i;
    } desc_t;

    function automatic cls_t classify(input logic [7:0] pos, input logic [5:0] status);
        cls_t c;
        if (pos == 8'hFF || status == 6'h3F) begin
            c = CLS_INVALID;
        end else if (pos >= LEN_LIM) begin
            c = CLS_OOR;
        end else begin
            c = CLS_OK;
        end
        return c;
    endfunction

    function automatic logic [7:0] format_resp(input cls_t c, input logic [3:0] base);
        logic [7:0] r;
        case (c)
            CLS_OK:  r = {4'h0, base};
            CLS_OOR: r = 8'h04;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Base memory (not reset; survives a mid-batch reset)
    // -----------------------------------------------------------------------
    logic [3:0]  base_mem [MEM_DEPTH];
    logic [16:0] wr_addr;

    assign wr_addr = {base_wr_read_num, base_wr_pos};

    always_ff @(posedge Clk_32UI) begin
        if (base_wr_en) begin
            base_mem[wr_addr] <= base_wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // S1: register address and class
    // -----------------------------------------------------------------------
    cls_t        cls_p0;
    logic [16:0] addr_p0;

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            cls_p0 <= CLS_INVALID;
        end else begin
            cls_p0 <= classify(query_position_2RAM, query_status_2RAM);
        end
    end

    // Address is data only; an INVALID class masks whatever it holds.
    always_ff @(posedge Clk_32UI) begin
        addr_p0 <= {query_read_num_2RAM, query_position_2RAM[6:0]};
    end

    // -----------------------------------------------------------------------
    // S2: synchronous base read
    // -----------------------------------------------------------------------
    cls_t       cls_p1;
    logic [3:0] base_p1;
    logic [3:0] rd_base;

`ifdef RQS_WR_BYPASS_EN
    // Forward the base being written this cycle to the same address.
    assign rd_base = (base_wr_en && (wr_addr == addr_p0)) ? base_wr_data
                                                          : base_mem[addr_p0];
`else
    // Read-first: the non-blocking write lands after this read samples.
    assign rd_base = base_mem[addr_p0];
`endif

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            cls_p1 <= CLS_INVALID;
        end else begin
            cls_p1 <= cls_p0;
        end
    end

    always_ff @(posedge Clk_32UI) begin
        base_p1 <= rd_base;
    end

    // -----------------------------------------------------------------------
    // S3: registered response
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            new_read_query_2Queue <= 8'hFF;
        end else begin
            new_read_query_2Queue <= format_resp(cls_p1, base_p1);
        end
    end

    // -----------------------------------------------------------------------
    // Descriptor FIFO (show-ahead)
    // -----------------------------------------------------------------------
    desc_t          fifo_mem [DESC_DEPTH];
    desc_t          head;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic           do_push;
    logic           do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Full is judged on registered pointers, so a same-cycle pop never frees
    // room for that cycle's push.
    assign do_push = desc_valid && !fifo_full;
    assign do_pop  = new_read && !fifo_empty;

    always_ff @(posedge Clk_32UI) begin
        if (do_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{read_num:  desc_read_num,
                                          ik_x0:     desc_ik_x0,
                                          ik_x1:     desc_ik_x1,
                                          ik_x2:     desc_ik_x2,
                                          ik_info:   desc_ik_info,
                                          forward_i: desc_forward_i};
        end
    end

    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (new_read && fifo_empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Storage is never reset; gating with empty keeps the outputs at zero
    // after reset and whenever nothing is queued.
    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head = fifo_mem[rd_ptr[AW-1:0]];
        end
    end

    assign desc_ready     = !fifo_full;
    assign new_read_valid = !fifo_empty;
    assign new_read_num   = head.read_num;
    assign new_ik_x0      = head.ik_x0;
    assign new_ik_x1      = head.ik_x1;
    assign new_ik_x2      = head.ik_x2;
    assign new_ik_info    = head.ik_info;
    assign new_forward_i  = head.forward_i;

    // -----------------------------------------------------------------------
    // Batch load status (batch_done takes priority)
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk_32UI or negedge reset_n) begin
        if (!reset_n) begin
            load_done <= 1'b0;
        end else if (batch_done) begin
            load_done <= 1'b1;
        end else if (batch_start) begin
            load_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_read_query_server.sv
module tb_read_query_server;

    logic        clk;
    logic        reset_n;
    logic        base_wr_en;
    logic [9:0]  base_wr_read_num;
    logic [6:0]  base_wr_pos;
    logic [3:0]  base_wr_data;
    logic        batch_start;
    logic        batch_done;
    logic        desc_valid;
    logic        desc_ready;
    logic [9:0]  desc_read_num;
    logic [63:0] desc_ik_x0, desc_ik_x1, desc_ik_x2, desc_ik_info;
    logic [6:0]  desc_forward_i;
    logic        new_read;
    logic        new_read_valid;
    logic        load_done;
    logic [9:0]  new_read_num;
    logic [63:0] new_ik_x0, new_ik_x1, new_ik_x2, new_ik_info;
    logic [6:0]  new_forward_i;
    logic [7:0]  query_position;
    logic [9:0]  query_read_num;
    logic [5:0]  query_status;
    logic [7:0]  resp;
    logic        underflow_err;

    int checks = 0;
    int errors = 0;

    read_query_server dut (
        .Clk_32UI              (clk),
        .reset_n               (reset_n),
        .base_wr_en            (base_wr_en),
        .base_wr_read_num      (base_wr_read_num),
        .base_wr_pos           (base_wr_pos),
        .base_wr_data          (base_wr_data),
        .batch_start           (batch_start),
        .batch_done            (batch_done),
        .desc_valid            (desc_valid),
        .desc_ready            (desc_ready),
        .desc_read_num         (desc_read_num),
        .desc_ik_x0            (desc_ik_x0),
        .desc_ik_x1            (desc_ik_x1),
        .desc_ik_x2            (desc_ik_x2),
        .desc_ik_info          (desc_ik_info),
        .desc_forward_i        (desc_forward_i),
        .new_read              (new_read),
        .new_read_valid        (new_read_valid),
        .load_done             (load_done),
        .new_read_num          (new_read_num),
        .new_ik_x0             (new_ik_x0),
        .new_ik_x1             (new_ik_x1),
        .new_ik_x2             (new_ik_x2),
        .new_ik_info           (new_ik_info),
        .new_forward_i         (new_forward_i),
        .query_position_2RAM   (query_position),
        .query_read_num_2RAM   (query_read_num),
        .query_status_2RAM     (query_status),
        .new_read_query_2Queue (resp),
        .underflow_err         (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required < 2000000", $time);
        $fatal(1);
    end

    typedef struct packed {
        logic [7:0] pos;
        logic [9:0] rn;
        logic [5:0] st;
        logic [7:0] exp;
    } qvec_t;

    localparam int NQ = 13;
    qvec_t tbl [NQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ikval(input int k, input logic [9:0] rn);
        return {8'(k + 1), 46'h0, rn};
    endfunction

    function automatic logic [6:0] fival(input logic [9:0] rn);
        return 7'(rn * 3 + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_query();
        query_position = 8'hFF;
        query_read_num = 10'd0;
        query_status   = 6'h3F;
    endtask

    task automatic drive_query(input logic [7:0] pos, input logic [9:0] rn, input logic [5:0] st);
        query_position = pos;
        query_read_num = rn;
        query_status   = st;
    endtask

    task automatic write_base(input logic [9:0] rn, input logic [6:0] pos, input logic [3:0] b);
        base_wr_en       = 1'b1;
        base_wr_read_num = rn;
        base_wr_pos      = pos;
        base_wr_data     = b;
        tick();
        base_wr_en       = 1'b0;
    endtask

    task automatic set_desc(input logic [9:0] rn);
        desc_read_num  = rn;
        desc_ik_x0     = ikval(0, rn);
        desc_ik_x1     = ikval(1, rn);
        desc_ik_x2     = ikval(2, rn);
        desc_ik_info   = ikval(3, rn);
        desc_forward_i = fival(rn);
    endtask

    task automatic push(input logic [9:0] rn);
        set_desc(rn);
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic pop();
        new_read = 1'b1;
        tick();
        new_read = 1'b0;
    endtask

    // Query driven now; response checked in the cycle three edges later.
    task automatic query_check(input string name, input logic [7:0] pos, input logic [9:0] rn,
                               input logic [7:0] exp);
        drive_query(pos, rn, 6'd1);
        tick();
        idle_query();
        @(posedge clk);
        tick();
        chk(name, {56'h0, resp}, {56'h0, exp});
    endtask

    task automatic chk_head(input string name, input logic [9:0] rn);
        chk({name, ".read_num"},  {54'h0, new_read_num}, {54'h0, rn});
        chk({name, ".ik_x0"},     new_ik_x0, ikval(0, rn));
        chk({name, ".ik_x1"},     new_ik_x1, ikval(1, rn));
        chk({name, ".ik_x2"},     new_ik_x2, ikval(2, rn));
        chk({name, ".ik_info"},   new_ik_info, ikval(3, rn));
        chk({name, ".forward_i"}, {57'h0, new_forward_i}, {57'h0, fival(rn)});
    endtask

    initial begin
        logic [7:0] exp_q;

        //            pos     rn      st     expected response
        tbl[0]  = '{8'd10,  10'd5, 6'd1,  8'h03};   // basic query
        tbl[1]  = '{8'd0,   10'd7, 6'd1,  8'h00};   // back-to-back A
        tbl[2]  = '{8'd1,   10'd7, 6'd2,  8'h01};   // C
        tbl[3]  = '{8'd2,   10'd7, 6'd1,  8'h02};   // G
        tbl[4]  = '{8'd3,   10'd7, 6'd1,  8'h03};   // T
        tbl[5]  = '{8'd101, 10'd7, 6'd1,  8'h04};   // first out-of-range position
        tbl[6]  = '{8'hFF,  10'd7, 6'd1,  8'hFF};   // idle position
        tbl[7]  = '{8'd3,   10'd7, 6'h3F, 8'hFF};   // idle status
        tbl[8]  = '{8'd100, 10'd9, 6'd1,  8'h02};   // last valid position
        tbl[9]  = '{8'd200, 10'd9, 6'd1,  8'h04};
        tbl[10] = '{8'd50,  10'd7, 6'd0,  8'h04};   // stored N base
        tbl[11] = '{8'd127, 10'd9, 6'd1,  8'h04};
        tbl[12] = '{8'hFE,  10'd7, 6'd1,  8'h04};   // FE is a real request, out of range

        reset_n     = 1'b0;
        base_wr_en  = 1'b0;
        base_wr_read_num = '0;
        base_wr_pos = '0;
        base_wr_data = '0;
        batch_start = 1'b0;
        batch_done  = 1'b0;
        desc_valid  = 1'b0;
        new_read    = 1'b0;
        set_desc(10'd0);
        idle_query();

        // Reset state
        @(posedge clk);
        tick();
        chk("rst.resp",           {56'h0, resp}, 64'hFF);
        chk("rst.new_read_valid", {63'h0, new_read_valid}, 64'h0);
        chk("rst.desc_ready",     {63'h0, desc_ready}, 64'h1);
        chk("rst.load_done",      {63'h0, load_done}, 64'h0);
        chk("rst.underflow_err",  {63'h0, underflow_err}, 64'h0);
        chk("rst.new_read_num",   {54'h0, new_read_num}, 64'h0);
        chk("rst.new_ik_x0",      new_ik_x0, 64'h0);
        reset_n = 1'b1;
        tick();

        // Preload bases
        write_base(10'd5,  7'd10,  4'd3);
        write_base(10'd7,  7'd0,   4'd0);
        write_base(10'd7,  7'd1,   4'd1);
        write_base(10'd7,  7'd2,   4'd2);
        write_base(10'd7,  7'd3,   4'd3);
        write_base(10'd9,  7'd100, 4'd2);
        write_base(10'd7,  7'd50,  4'd4);
        write_base(10'd11, 7'd3,   4'd2);
        tick();
        tick();
        tick();

        // Table-driven query stream, one request per cycle
        for (int i = 0; i < NQ + 3; i++) begin
            exp_q = (i >= 3) ? tbl[i-3].exp : 8'hFF;
            chk($sformatf("query%0d", i - 3), {56'h0, resp}, {56'h0, exp_q});
            if (i < NQ) drive_query(tbl[i].pos, tbl[i].rn, tbl[i].st);
            else        idle_query();
            tick();
        end
        idle_query();
        tick();

        // Write/read collision on the S2 read address
        drive_query(8'd3, 10'd11, 6'd1);
        tick();
        idle_query();
        base_wr_en       = 1'b1;
        base_wr_read_num = 10'd11;
        base_wr_pos      = 7'd3;
        base_wr_data     = 4'd1;
        tick();
        base_wr_en = 1'b0;
        tick();
`ifdef RQS_WR_BYPASS_EN
        chk("collision.resp", {56'h0, resp}, 64'h01);
`else
        chk("collision.resp", {56'h0, resp}, 64'h02);
`endif
        query_check("collision.after", 8'd3, 10'd11, 8'h01);

        // FIFO fill to full
        for (int i = 0; i < 16; i++) begin
            push(10'(i));
            chk($sformatf("fill%0d.valid", i), {63'h0, new_read_valid}, 64'h1);
            chk($sformatf("fill%0d.ready", i), {63'h0, desc_ready}, (i < 15) ? 64'h1 : 64'h0);
        end
        chk_head("full.head", 10'd0);

        // Full: pop accepted, same-cycle push refused
        set_desc(10'd99);
        desc_valid = 1'b1;
        new_read   = 1'b1;
        tick();
        desc_valid = 1'b0;
        new_read   = 1'b0;
        chk("fullpp.ready", {63'h0, desc_ready}, 64'h1);

        // Drain; entry 99 must never appear
        for (int i = 1; i < 16; i++) begin
            chk_head($sformatf("drain%0d", i), 10'(i));
            pop();
        end
        chk("drain.valid",     {63'h0, new_read_valid}, 64'h0);
        chk("drain.ready",     {63'h0, desc_ready}, 64'h1);
        chk("drain.head_zero", {54'h0, new_read_num}, 64'h0);
        chk("drain.underflow", {63'h0, underflow_err}, 64'h0);

        // One entry: push and pop together keep one entry, head advances
        push(10'd20);
        set_desc(10'd21);
        desc_valid = 1'b1;
        new_read   = 1'b1;
        tick();
        desc_valid = 1'b0;
        new_read   = 1'b0;
        chk("pp1.valid", {63'h0, new_read_valid}, 64'h1);
        chk_head("pp1.head", 10'd21);
        pop();
        chk("pp1.drained", {63'h0, new_read_valid}, 64'h0);

        // Empty pop: ignored, flags underflow
        pop();
        chk("uf.flag",  {63'h0, underflow_err}, 64'h1);
        chk("uf.valid", {63'h0, new_read_valid}, 64'h0);
        push(10'd30);
        chk("uf.push_valid", {63'h0, new_read_valid}, 64'h1);
        chk_head("uf.head", 10'd30);
        pop();
        chk("uf.drained", {63'h0, new_read_valid}, 64'h0);

        // Empty pop with same-cycle push: push still lands
        set_desc(10'd31);
        desc_valid = 1'b1;
        new_read   = 1'b1;
        tick();
        desc_valid = 1'b0;
        new_read   = 1'b0;
        chk("uf2.valid", {63'h0, new_read_valid}, 64'h1);
        chk_head("uf2.head", 10'd31);
        chk("uf2.sticky", {63'h0, underflow_err}, 64'h1);
        pop();

        // load_done control
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        chk("ld.set", {63'h0, load_done}, 64'h1);
        batch_start = 1'b1;
        tick();
        batch_start = 1'b0;
        chk("ld.clear", {63'h0, load_done}, 64'h0);
        batch_start = 1'b1;
        batch_done  = 1'b1;
        tick();
        batch_start = 1'b0;
        batch_done  = 1'b0;
        chk("ld.both", {63'h0, load_done}, 64'h1);
        chk("ld.fifo_untouched", {63'h0, new_read_valid}, 64'h0);

        // Reset mid-stream: 5 entries queued, queries in flight
        for (int i = 0; i < 5; i++) push(10'(40 + i));
        chk("mid.valid_before", {63'h0, new_read_valid}, 64'h1);
        drive_query(8'd10, 10'd5, 6'd1);
        tick();
        drive_query(8'd0, 10'd7, 6'd1);
        tick();
        drive_query(8'd1, 10'd7, 6'd1);
        tick();
        idle_query();
        chk("mid.resp_before", {56'h0, resp}, 64'h03);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid.resp_rst",      {56'h0, resp}, 64'hFF);
        chk("mid.valid_rst",     {63'h0, new_read_valid}, 64'h0);
        chk("mid.ready_rst",     {63'h0, desc_ready}, 64'h1);
        chk("mid.load_done_rst", {63'h0, load_done}, 64'h0);
        chk("mid.underflow_rst", {63'h0, underflow_err}, 64'h0);
        @(posedge clk);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mid.post%0d", i), {56'h0, resp}, 64'hFF);
            tick();
        end
        chk("mid.valid_post", {63'h0, new_read_valid}, 64'h0);
        query_check("mid.base_kept", 8'd10, 10'd5, 8'h03);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_query_server.md
# read_query_server

Read-side server for the SMEM forward/backward pipeline queue. Stores the current batch of reads as 4-bit bases and answers per-cycle base queries with a fixed 3-cycle latency, aligned to the queue's 3-stage wait pipe. Supplies new-read descriptors to the queue through a show-ahead FIFO using the queue's `new_read` / `new_read_valid` / `load_done` handshake. Sits between the host batch loader and the queue.

## Interface
Parameters:
- `READ_CNT`, 1024: reads per batch; must match the 10-bit `read_num`.
- `READ_LEN`, 101: bases per read; positions 0..READ_LEN-1 are valid.
- `DESC_DEPTH`, 16: descriptor FIFO entries; must be a power of 2.

Ports:
- `Clk_32UI` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `base_wr_en` in 1: base write strobe.
- `base_wr_read_num` in 10: read index for the base write.
- `base_wr_pos` in 7: base position for the base write.
- `base_wr_data` in 4: base code; 0-3 are ACGT, 4 is N.
- `batch_start` in 1: pulse that clears `load_done`.
- `batch_done` in 1: pulse that sets `load_done`.
- `desc_valid` in 1: descriptor push request.
- `desc_ready` out 1: FIFO is not full.
- `desc_read_num` in 10: descriptor read number.
- `desc_ik_x0`, `desc_ik_x1`, `desc_ik_x2`, `desc_ik_info` in 64 each: descriptor initial interval.
- `desc_forward_i` in 7: descriptor start position.
- `new_read` in 1: pop request from the queue.
- `new_read_valid` out 1: FIFO is non-empty.
- `load_done` out 1: batch fully loaded.
- `new_read_num` out 10: head-of-FIFO read number.
- `new_ik_x0`, `new_ik_x1`, `new_ik_x2`, `new_ik_info` out 64 each: head-of-FIFO interval.
- `new_forward_i` out 7: head-of-FIFO start position.
- `query_position_2RAM` in 8: query position; 8'hFF means no request.
- `query_read_num_2RAM` in 10: query read index.
- `query_status_2RAM` in 6: query status; 6'h3F means no request.
- `new_read_query_2Queue` out 8: query response.
- `underflow_err` out 1: sticky flag, set on a pop from an empty FIFO.

## Operation
- **Base memory**
  - READ_CNT×128 entries of 4 bits, addressed {read_num, pos[6:0]}.
  - Synchronous write when `base_wr_en` is high. Not reset.
- **Query pipeline**
  - S1 registers the address and a class. Class is one of:
    - INVALID: position is 8'hFF or status is 6'h3F.
    - OOR: position ≥ READ_LEN.
    - OK: otherwise.
  - S2 performs the synchronous memory read.
  - S3 registers the response:
    - OK: {4'h0, base}.
    - OOR: 8'h04.
    - INVALID: 8'hFF.
  - Fully pipelined: one query accepted per cycle, with no backpressure.
- **Write/read collision**
  - Collision means the S2 read address equals the write address in the same cycle.
  - Without the bypass feature, the read returns the old data (read-first).
- **Descriptor FIFO** (273 bits: read_num, 4×ik, forward_i)
  - Push happens when `desc_valid` and `desc_ready` are both high.
  - Pop happens when `new_read` and `new_read_valid` are both high.
  - The `new_*` outputs always show the head entry combinationally from registered storage.
  - Pointers are log2(DESC_DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the remaining bits are equal.
  - Simultaneous push and pop when non-empty and not full: both take effect, and the count is unchanged.
  - Full: push is refused, and a pop in the same cycle does not make that cycle's push legal.
  - Empty: a pop is ignored and sets `underflow_err`. A same-cycle push is still accepted.
- **load_done**
  - Set by `batch_done`, cleared by `batch_start`.
  - If both pulse in the same cycle, `batch_done` wins.
  - No effect on FIFO contents.

## Timing
- **Query latency:** a request driven combinationally in cycle t produces a response valid throughout cycle t+3. It is sampled at the edge ending t+3, which lines up with the queue's L2→f_data capture.
- **FIFO:** a push at edge e makes `new_read_valid` high after e. A pop at edge e advances the head after e.
- `desc_ready` and `new_read_valid` come from registered pointers only.
- **Reset values (asynchronous assert):**
  - `new_read_query_2Queue` = 8'hFF, and the S1-S3 pipeline classes are set to INVALID.
  - FIFO pointers are 0, so `new_read_valid` = 0 and `desc_ready` = 1.
  - `load_done` = 0, `underflow_err` = 0.
  - The `new_*` data outputs are 0.
- **Reset mid-operation:**
  - In-flight queries are dropped; the 3 cycles after release return 8'hFF.
  - FIFO contents are discarded. Base memory is retained.

## Configuration
- **`RQS_WR_BYPASS_EN` defined:** on a collision, S2 forwards `base_wr_data`, so the response returns the newly written base.
- **Undefined:** read-first; the collision returns the previously stored base.
- FIFO, handshake and latency behaviour are identical in both builds.

## Test plan
- **Basic query:** write base 2'h3 at read 5, pos 10. Three cycles later, query (10, 5, status 1). The response is 8'h03 in exactly cycle t+3 and 8'hFF in cycles t+1 and t+2.
- **Back-to-back queries:** 4 queries on consecutive cycles at positions 0-3, pre-written with 0, 1, 2, 3. The responses are 00, 01, 02, 03 on cycles t+3 to t+6. Position 101 returns 04; position FF returns FF.
- **FIFO fill and drain:** push 16 descriptors (read_num 0-15) and check that `desc_ready` drops after the 16th. Pulse `new_read` 16 times; read_num is 0-15 in order and `new_read_valid` ends at 0.
- **Simultaneous push and pop:**
  - With 1 entry: push and pop in the same cycle leave 1 entry and the head advances.
  - When empty: pop alone sets `underflow_err` and the pointers do not move.
- **Collision:** write base 1 over stored base 2 in the same cycle as the S2 read of that address. The response is 02 without the macro and 01 with `RQS_WR_BYPASS_EN`.
- **Reset mid-stream:** assert `reset_n` low with 3 queries in flight and 5 entries in the FIFO. Outputs go to FF immediately, `new_read_valid` = 0 and `load_done` = 0. After release, a previously written base still reads back correctly.
